// File: rtl/mem_drain_if.sv
// Handshake/bus bundle between mem_drain, the acquisition memory and the downstream consumer.
// Optional word_parity signal is present only when MEM_DRAIN_PARITY_EN is defined.
interface mem_drain_if;
  logic       full;
  logic       mem_write;
  logic [1:0] data_in;
  logic       read;
  logic [1:0] address;
  logic [7:0] word_out;
  logic       word_valid;
  logic       word_ready;
  logic       done;
`ifdef MEM_DRAIN_PARITY_EN
  logic       word_parity;

  modport master (
    input  full, mem_write, data_in, word_ready,
    output read, address, word_out, word_valid, done, word_parity
  );
  modport slave (
    output full, mem_write, data_in, word_ready,
    input  read, address, word_out, word_valid, done, word_parity
  );
`else
  modport master (
    input  full, mem_write, data_in, word_ready,
    output read, address, word_out, word_valid, done
  );
  modport slave (
    output full, mem_write, data_in, word_ready,
    input  read, address, word_out, word_valid, done
  );
`endif
endinterface

// File: rtl/mem_drain.sv
// Drains the 4x2-bit acquisition memory into one packed 8-bit word on a rising full flag.
// Build option MEM_DRAIN_PARITY_EN adds a registered even-parity output.
//
// state   | meaning
// IDLE    | waiting for a 0->1 edge on full
// READ    | read strobe at address idx, retried while mem_write blocks it
// CAPT    | load returned sample into slot idx
// PRESENT | word_valid high until word_ready accepts it
module mem_drain (
  input  logic         new_clk,
  input  logic         reset,
  mem_drain_if.master  bus
);

  typedef enum logic [1:0] {IDLE, READ, CAPT, PRESENT} state_t;

  state_t     state, state_nxt;
  logic       full_d;
  logic [1:0] idx, idx_nxt;
  logic [7:0] word, word_nxt;
  logic       done_r, done_nxt;
  logic       start;

  assign start = bus.full & ~full_d;

  always_ff @(posedge new_clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      full_d <= 1'b0;
      idx    <= 2'd0;
      word   <= 8'd0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      full_d <= bus.full;
      idx    <= idx_nxt;
      word   <= word_nxt;
      done_r <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    word_nxt  = word;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          idx_nxt   = 2'd0;
          state_nxt = READ;
        end
      end
      READ: begin
        // memory gives writes priority, so a colliding read must be reissued
        if (!bus.mem_write) state_nxt = CAPT;
      end
      CAPT: begin
        word_nxt[{idx, 1'b0} +: 2] = bus.data_in;
        if (idx == 2'd3) begin
          state_nxt = PRESENT;
        end else begin
          idx_nxt   = idx + 2'd1;
          state_nxt = READ;
        end
      end
      PRESENT: begin
        if (bus.word_ready) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.read       = (state == READ);
  assign bus.address    = idx;
  assign bus.word_out   = word;
  assign bus.word_valid = (state == PRESENT);
  assign bus.done       = done_r;

`ifdef MEM_DRAIN_PARITY_EN
  logic parity;

  always_ff @(posedge new_clk or posedge reset) begin
    if (reset)              parity <= 1'b0;
    else if (state == CAPT) parity <= ^word_nxt;
  end

  assign bus.word_parity = parity;
`endif

endmodule

// File: tb/tb_mem_drain.sv
// Self-checking bench for mem_drain: directed scenarios plus randomized drains
// compared against a cycle schedule derived from the drain rules.
module tb_mem_drain;

  logic new_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 new_clk = ~new_clk;

  mem_drain_if bus();

  mem_drain dut (
    .new_clk (new_clk),
    .reset   (reset),
    .bus     (bus.master)
  );

  // Acquisition memory: registered data_out, writes win over reads.
  logic [1:0] mem [4];
  always @(posedge new_clk)
    if (bus.read && !bus.mem_write) bus.data_in <= mem[bus.address];

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       rd;
    logic [1:0] addr;
    logic       vld;
    logic       dn;
    logic       mw;
    logic       rdy;
    logic       fl;
    logic       wchk;
  } step_t;

  step_t sched[$];
  int    coll [4];
  int    rdelay;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic step_t mk(input logic rd, input logic [1:0] addr, input logic vld,
                               input logic dn, input logic mw, input logic rdy,
                               input logic fl, input logic wchk);
    step_t s;
    s.rd = rd; s.addr = addr; s.vld = vld; s.dn = dn;
    s.mw = mw; s.rdy = rdy; s.fl = fl; s.wchk = wchk;
    return s;
  endfunction

  function automatic logic rnd_bit();
    return ($urandom & 32'd1) != 32'd0;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_read"},  bus.read,       1'b0);
    check({tag, "_addr"},  bus.address,    2'd0);
    check({tag, "_word"},  bus.word_out,   8'h00);
    check({tag, "_valid"}, bus.word_valid, 1'b0);
    check({tag, "_done"},  bus.done,       1'b0);
`ifdef MEM_DRAIN_PARITY_EN
    check({tag, "_par"},   bus.word_parity, 1'b0);
`endif
  endtask

  // One drain: expected timeline is built from the rules (READ+collisions, CAPT per entry,
  // PRESENT for rdelay+1 cycles, one done cycle), then replayed cycle by cycle.
  task automatic do_drain(input int abort_at, input bit toggle_present);
    logic [7:0] exp_word;
    logic [1:0] a2;
    exp_word = {mem[3], mem[2], mem[1], mem[0]};
    sched.delete();
    for (int a = 0; a < 4; a++) begin
      a2 = a[1:0];
      for (int j = 0; j <= coll[a]; j++)
        sched.push_back(mk(1'b1, a2, 1'b0, 1'b0, j < coll[a], rnd_bit(), 1'b1, 1'b0));
      sched.push_back(mk(1'b0, a2, 1'b0, 1'b0, 1'b0, rnd_bit(), 1'b1, 1'b0));
    end
    for (int j = 0; j <= rdelay; j++)
      sched.push_back(mk(1'b0, 2'd3, 1'b1, 1'b0, 1'b0, j == rdelay,
                         !(toggle_present && j == 0), 1'b1));
    sched.push_back(mk(1'b0, 2'd3, 1'b0, 1'b1, 1'b0, rnd_bit(), 1'b1, 1'b1));
    // full stays high afterwards: no restart may happen
    for (int j = 0; j < 3; j++)
      sched.push_back(mk(1'b0, 2'd3, 1'b0, 1'b0, 1'b0, rnd_bit(), 1'b1, 1'b1));

    @(negedge new_clk);
    bus.full = 1'b0; bus.mem_write = 1'b0; bus.word_ready = 1'b0;
    @(negedge new_clk);
    bus.full = 1'b1;
    @(posedge new_clk);
    for (int i = 0; i < sched.size(); i++) begin
      #1;
      bus.mem_write  = sched[i].mw;
      bus.word_ready = sched[i].rdy;
      bus.full       = sched[i].fl;
      @(negedge new_clk);
      check($sformatf("read_c%0d", i),  bus.read,       sched[i].rd);
      check($sformatf("addr_c%0d", i),  bus.address,    sched[i].addr);
      check($sformatf("valid_c%0d", i), bus.word_valid, sched[i].vld);
      check($sformatf("done_c%0d", i),  bus.done,       sched[i].dn);
      if (sched[i].wchk) begin
        check($sformatf("word_c%0d", i), bus.word_out, exp_word);
`ifdef MEM_DRAIN_PARITY_EN
        check($sformatf("par_c%0d", i), bus.word_parity, ^exp_word);
`endif
      end
      if (i == abort_at) begin
        #2;
        reset    = 1'b1;
        bus.full = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(posedge new_clk);
        @(negedge new_clk);
        reset = 1'b0;
        return;
      end
      @(posedge new_clk);
    end
    #1;
    bus.full = 1'b0; bus.mem_write = 1'b0; bus.word_ready = 1'b0;
  endtask

  task automatic set_mem(input logic [1:0] m0, input logic [1:0] m1,
                         input logic [1:0] m2, input logic [1:0] m3);
    mem[0] = m0; mem[1] = m1; mem[2] = m2; mem[3] = m3;
  endtask

  task automatic no_coll();
    for (int a = 0; a < 4; a++) coll[a] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.full = 1'b0; bus.mem_write = 1'b0; bus.word_ready = 1'b0;
    set_mem(2'd0, 2'd0, 2'd0, 2'd0);
    no_coll();
    rdelay = 0;

    #12;
    check_reset_outputs("reset");
    @(negedge new_clk);
    reset = 1'b0;
    @(negedge new_clk);
    check_reset_outputs("post_reset");

    // basic drain
    set_mem(2'd1, 2'd2, 2'd3, 2'd0);
    do_drain(-1, 1'b0);
    check("basic_word", bus.word_out, 8'h39);

    // backpressure
    set_mem(2'd2, 2'd0, 2'd1, 2'd3);
    rdelay = 5;
    do_drain(-1, 1'b0);

    // write collision on address 2 for two cycles
    set_mem(2'd3, 2'd1, 2'd2, 2'd0);
    rdelay = 0;
    coll[2] = 2;
    do_drain(-1, 1'b0);
    check("coll_word", bus.word_out, 8'h27);

    // full toggled during PRESENT is ignored; fresh edge in IDLE drains again
    no_coll();
    set_mem(2'd0, 2'd3, 2'd0, 2'd2);
    rdelay = 3;
    do_drain(-1, 1'b1);
    set_mem(2'd1, 2'd1, 2'd2, 2'd2);
    rdelay = 0;
    do_drain(-1, 1'b0);

    // async reset during CAPT of address 1, then a complete drain
    set_mem(2'd3, 2'd2, 2'd1, 2'd0);
    do_drain(3, 1'b0);
    set_mem(2'd2, 2'd3, 2'd0, 2'd1);
    do_drain(-1, 1'b0);

    // parity corners
    set_mem(2'd3, 2'd3, 2'd3, 2'd1);
    do_drain(-1, 1'b0);
    check("par_word", bus.word_out, 8'h7F);
`ifdef MEM_DRAIN_PARITY_EN
    check("par_one", bus.word_parity, 1'b1);
`endif
    set_mem(2'd0, 2'd0, 2'd0, 2'd0);
    do_drain(-1, 1'b0);
    check("zero_word", bus.word_out, 8'h00);
`ifdef MEM_DRAIN_PARITY_EN
    check("par_zero", bus.word_parity, 1'b0);
`endif

    // randomized drains
    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < 4; a++) begin
        mem[a]  = 2'($urandom_range(0, 3));
        coll[a] = $urandom_range(0, 2);
      end
      rdelay = $urandom_range(0, 4);
      do_drain(-1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
